// File: rtl/uart_pkg.sv
// Shared UART link definitions: ASCII framing characters and the decimal parser state encoding.
package uart_pkg;

    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_MINUS = 8'h2D;
    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_9     = 8'h39;

    // Unsigned magnitude width: 5 decimal digits (max 99999) fit in 17 bits.
    localparam int ACC_W = 17;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_DIGITS,
        PS_DISCARD,
        PS_CHECK
    } parser_state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CHR_0) && (c <= CHR_9);
    endfunction

endpackage

// File: rtl/uart_rx_dec_parser_rx.sv
// 8N1 byte receiver: samples mid-bit after a double-flop synchroniser, pulses o_Rx_DV for one cycle per byte.
// Frames with a low stop bit are dropped silently.
module UART_RX #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       sysclk,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {
        RX_S_IDLE,
        RX_S_START,
        RX_S_DATA,
        RX_S_STOP
    } rx_state_t;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             dv_q, dv_d;
    logic [1:0]       sync_q;
    logic             rx;

    assign rx = sync_q[1];

    always_ff @(posedge sysclk) begin
        if (!i_Rst_n) begin
            state_q <= RX_S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            sync_q  <= {sync_q[0], i_Rx_Serial};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        case (state_q)
            RX_S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx) state_d = RX_S_START;
            end
            RX_S_START: begin
                // Re-check at mid start bit so line glitches do not start a byte.
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx ? RX_S_IDLE : RX_S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    byte_d[idx_q] = rx;
                    if (idx_q == 3'd7) state_d = RX_S_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    dv_d    = rx;
                    state_d = RX_S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_S_IDLE;
        endcase
    end

    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;

endmodule

// File: rtl/uart_rx_dec_parser.sv
// UART receive end of the ASCII-decimal link: parses [-]d{1..5}CR into a signed DATA_W value.
// Strobes arrive 2 cycles after the CR byte; no backpressure, strobes are fire-and-forget.
module uart_rx_dec_parser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_DIGITS   = 5,
    parameter int DATA_W       = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_Rx_Serial,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic              o_frame_error,
    output logic              RX_IDLE
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] MAG_POS = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic [ACC_W-1:0] MAG_NEG = ACC_W'(2 ** (DATA_W - 1));

    logic       rx_dv;
    logic [7:0] rx_byte;

    UART_RX #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .sysclk      (Clk),
        .i_Rst_n     (Rst_n),
        .i_Rx_Serial (i_Rx_Serial),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte)
    );

    parser_state_t     state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              ferr_q, ferr_d;

    logic [ACC_W-1:0]  digit_val;
    logic [ACC_W-1:0]  acc_next;
    logic [DATA_W-1:0] mag;
    logic              in_range;
    logic              rx_digit;

    assign rx_digit  = is_digit(rx_byte);
    assign digit_val = ACC_W'(rx_byte[3:0]);
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + digit_val;
    assign mag       = acc_q[DATA_W-1:0];
    assign in_range  = sign_q ? (acc_q <= MAG_NEG) : (acc_q <= MAG_POS);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= PS_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            bad_q   <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            bad_q   <= bad_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        bad_d   = bad_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            PS_IDLE: begin
                acc_d  = '0;
                cnt_d  = '0;
                sign_d = 1'b0;
                bad_d  = 1'b0;
                if (rx_dv) begin
                    if (rx_byte == CHR_MINUS) begin
                        sign_d  = 1'b1;
                        state_d = PS_DIGITS;
                    end else if (rx_digit) begin
                        acc_d   = digit_val;
                        cnt_d   = CNT_W'(1);
                        state_d = PS_DIGITS;
                    end else if (rx_byte != CHR_CR && rx_byte != CHR_LF) begin
                        state_d = PS_DISCARD;
                    end
                end
            end
            PS_DIGITS: begin
                if (rx_dv) begin
                    if (rx_digit) begin
                        if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                            acc_d = acc_next;
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            state_d = PS_DISCARD;
                        end
                    end else if (rx_byte == CHR_CR) begin
                        // A lone '-' is rejected via CHECK so every strobe has the same latency.
                        bad_d   = (cnt_q == '0);
                        state_d = PS_CHECK;
                    end else if (rx_byte != CHR_LF) begin
                        state_d = PS_DISCARD;
                    end
                end
            end
            PS_DISCARD: begin
                if (rx_dv && rx_byte == CHR_CR) begin
                    bad_d   = 1'b1;
                    state_d = PS_CHECK;
                end
            end
            PS_CHECK: begin
                state_d = PS_IDLE;
                if (!bad_q && in_range) begin
                    data_d = sign_q ? (DATA_W'(0) - mag) : mag;
                    vld_d  = 1'b1;
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: state_d = PS_IDLE;
        endcase
    end

    assign o_data        = data_q;
    assign o_data_valid  = vld_q;
    assign o_frame_error = ferr_q;
    assign RX_IDLE       = (state_q == PS_IDLE);

endmodule

// File: tb/tb_uart_rx_dec_parser.sv
// Directed frames driven onto the serial line; strobes counted by a negedge monitor.
module tb_uart_rx_dec_parser;

    localparam int CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx_line;
    logic [15:0] data;
    logic        data_vld;
    logic        frame_err;
    logic        rx_idle;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;

    uart_rx_dec_parser #(
        .CLKS_PER_BIT(CPB),
        .MAX_DIGITS  (5),
        .DATA_W      (16)
    ) dut (
        .Clk          (clk),
        .Rst_n        (rst_n),
        .i_Rx_Serial  (rx_line),
        .o_data       (data),
        .o_data_valid (data_vld),
        .o_frame_error(frame_err),
        .RX_IDLE      (rx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_vld)              n_valid++;
        if (frame_err)             n_err++;
        if (data_vld && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_line = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx_line = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic run_frame(input string tag, input string s, input int exp_v,
                             input int exp_e, input logic [15:0] exp_d);
        int v0;
        int e0;
        v0 = n_valid;
        e0 = n_err;
        send_str(s);
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check({tag, "_vld"},  32'(n_valid - v0), 32'(exp_v));
        check({tag, "_err"},  32'(n_err - e0),   32'(exp_e));
        check({tag, "_data"}, 32'(data),         32'(exp_d));
        check({tag, "_idle"}, 32'(rx_idle),      32'd1);
    endtask

    initial begin
        int v0;
        int e0;
        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data),      32'h0);
        check("rst_vld",  32'(data_vld),  32'h0);
        check("rst_err",  32'(frame_err), 32'h0);
        check("rst_idle", 32'(rx_idle),   32'h1);
        rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        run_frame("t1_neg123",  "-123\015",   1, 0, 16'hFF85);
        run_frame("t2_max",     "32767\015",  1, 0, 16'h7FFF);
        run_frame("t2_min",     "-32768\015", 1, 0, 16'h8000);
        run_frame("t3_ovf",     "32768\015",  0, 1, 16'h8000);
        run_frame("t3_novf",    "-32769\015", 0, 1, 16'h8000);
        run_frame("t3_99999",   "99999\015",  0, 1, 16'h8000);
        run_frame("t4_badch",   "12a4\015",   0, 1, 16'h8000);
        run_frame("t4_6dig",    "123456\015", 0, 1, 16'h8000);
        run_frame("t4_seven",   "7\015",      1, 0, 16'h0007);
        run_frame("t5_cr",      "\015",       0, 0, 16'h0007);
        run_frame("t5_lf",      "\012",       0, 0, 16'h0007);
        run_frame("t5_minus",   "-\015",      0, 1, 16'h0007);
        run_frame("t5_lead0",   "0045\015\012", 1, 0, 16'h002D);
        run_frame("t5_negzero", "-0\015",     1, 0, 16'h0000);
        run_frame("t5_lf_mid",  "1\0122\015", 1, 0, 16'h000C);

        v0 = n_valid;
        e0 = n_err;
        send_str("-98");
        repeat (CPB) @(posedge clk);
        @(negedge clk);
        check("t6_busy", 32'(rx_idle), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check("t6_vld",  32'(n_valid - v0), 32'h0);
        check("t6_err",  32'(n_err - e0),   32'h0);
        check("t6_data", 32'(data),         32'h0);
        check("t6_idle", 32'(rx_idle),      32'h1);
        run_frame("t6_five", "5\015", 1, 0, 16'h0005);

        check("never_both", 32'(n_both), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
